carfield_l2_port_arbiter: RTL and testbench
===========================================

# carfield_l2_port_arbiter

Shares the two L2 SRAM ports among `NumReq` on-chip requesters, such as the host, the PULP cluster DMA and the mailbox-driven engines. Each request is decoded by address into port 0 (`[L2Base, L2Base+PortSize)`) or port 1 (`[L2Base+PortSize, L2Base+2*PortSize)`). The block then arbitrates round-robin per port and routes in-order responses back to the originating requester. It sits between the requester-side memory interfaces and the two L2 port inputs of the L2 memory.

## Interface

Parameters:
- `NumReq`, 4: number of requesters (2..8).
- `AddrWidth`, 48: address width.
- `DataWidth`, 64: data width; byte enables are `DataWidth/8` bits wide.
- `L2Base`, 'h78000000: base address of port 0.
- `PortSize`, 'h00200000: size of each port window; must be a power of two.
- `MaxOutst`, 4: ID-FIFO depth per port, i.e. the maximum number of outstanding port transactions.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in NumReq: request valid, one bit per requester.
- `gnt_o` out NumReq: request accepted.
- `addr_i` in NumReq×AddrWidth: byte address.
- `we_i` in NumReq: write enable.
- `wdata_i` in NumReq×DataWidth: write data.
- `be_i` in NumReq×DataWidth/8: byte enables.
- `rvalid_o` out NumReq: response valid.
- `rdata_o` out NumReq×DataWidth: read data.
- `err_o` out NumReq: decode error; valid with `rvalid_o`.
- `port_req_o` out 2: request to L2 port 0/1.
- `port_gnt_i` in 2: L2 port accept.
- `port_addr_o` out 2×AddrWidth: port-relative address (`addr_i − port base`).
- `port_we_o`, `port_wdata_o`, `port_be_o` out: forwarded from the winning requester.
- `port_rvalid_i` in 2: L2 port response valid; responses arrive in order per port.
- `port_rdata_i` in 2×DataWidth: L2 port read data.

## Operation

- **Decode.** Port index = `(addr − L2Base) / PortSize` when in range. An address outside `[L2Base, L2Base+2*PortSize)` is a decode miss.
- **Eligibility.** A requester is eligible for port p only when all of the following hold:
  - it targets p;
  - it has zero outstanding transactions on the other port;
  - no error response is pending for it.
- This rule makes per-requester responses in order and means two responses can never collide.
- **Arbitration.** One round-robin pointer per port, reset value 0. The winner is the first eligible index at or after the pointer.
  - The pointer moves to `winner+1` (mod `NumReq`) only on a handshake (`port_req_o[p] & port_gnt_i[p]`).
  - Otherwise the pointer holds and the winner's payload is held on the port.
- **Request protocol.** The requester holds `req_i` and its payload stable until `gnt_o`. `gnt_o[i] = port_req_o[p] & port_gnt_i[p] & (winner == i)`.
- **ID FIFO.** Each port has an ID FIFO of depth `MaxOutst`. On a handshake the winner index is pushed.
  - When the FIFO is full, `port_req_o[p]` is 0. There is no bypass, even if `port_rvalid_i[p]` pops in the same cycle.
  - On `port_rvalid_i[p]` the head is popped, `rvalid_o[head]=1` and `rdata_o[head]=port_rdata_i[p]`.
  - Push and pop in the same cycle leave the count unchanged.
  - `port_rvalid_i` while the FIFO is empty is ignored.
- **Outstanding counters.** Each requester has a counter per port, incremented on push and decremented on pop, wide enough for `MaxOutst`.
- **Ports are independent.** Both ports may grant different requesters in the same cycle.

## Timing

- **Reset values.** All outputs are 0 during and after reset. FIFOs are empty, pointers are 0, counters are 0 and error-pending flags are clear.
- **Request path.** `req_i` → `port_req_o` is combinational, with zero added latency. `gnt_o` follows `port_gnt_i` in the same cycle.
- **Response path.** `port_rvalid_i` → `rvalid_o` is combinational in the same cycle.
- **Write responses.** Writes also receive a response; L2 returns `rvalid` for writes, and that response is routed like a read response.
- **Reset mid-operation.** Reset clears all state. Port responses arriving after reset land on empty FIFOs and are dropped. Requesters must also be reset.

## Configuration

- Macro: `CARFIELD_L2ARB_DECERR_EN`.
- **Defined.** A decode-miss request from a requester with no outstanding transactions is granted immediately (`gnt_o=1`, no port access) and sets its error-pending flag. In the next cycle the block drives `rvalid_o=1`, `err_o=1`, `rdata_o=0` and clears the flag.
- **Undefined.** There is no range check. The port is selected by address bit `log2(PortSize)` and the port address is `addr mod PortSize`. `err_o` is tied to 0.

## Test plan

- **Single read.** Req 0 reads 'h78000010; port 0 grants immediately and returns 'hDEAD 3 cycles later. Required: `port_addr_o[0]`='h10 and `rvalid_o[0]` with 'hDEAD in the port-response cycle.
- **Fairness.** All 4 requesters continuously target port 0 and `port_gnt_i[0]` is always 1. Required: grant order 0,1,2,3,0; port 1 stays idle.
- **Dual port.** Req 0 targets 'h78000000 and req 1 targets 'h78200000 in the same cycle. Required: both granted in that cycle; `port_addr_o[1]`='h0.
- **FIFO full.** `MaxOutst`=4 with port responses withheld. Required: only 4 grants, then `port_req_o[0]`=0. One `port_rvalid_i` re-enables the request in the next cycle.
- **Cross-port hazard.** Req 2 has 1 outstanding on port 0 and then targets port 1. Required: no grant until its port-0 response is delivered.
- **Decode error.** With `CARFIELD_L2ARB_DECERR_EN` defined, req 3 accesses 'h60000000. Required: `gnt_o[3]` in cycle t, then `rvalid_o[3]`=1 and `err_o[3]`=1 at t+1; no port request issued.

Source files
------------

// File: rtl/carfield_l2_port_arbiter.sv
// Shares the two L2 SRAM ports among NumReq requesters: address decode, per-port round-robin
// and in-order response routing. Define CARFIELD_L2ARB_DECERR_EN to range-check addresses.
module carfield_l2_port_arbiter #(
    parameter int unsigned          NumReq    = 4,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 64,
    parameter logic [AddrWidth-1:0] L2Base    = 'h78000000,
    parameter logic [AddrWidth-1:0] PortSize  = 'h00200000,
    parameter int unsigned          MaxOutst  = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_i,
    output logic [NumReq-1:0]                  gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0]                  we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0] be_i,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
    output logic [NumReq-1:0]                  err_o,
    output logic [1:0]                         port_req_o,
    input  logic [1:0]                         port_gnt_i,
    output logic [1:0][AddrWidth-1:0]          port_addr_o,
    output logic [1:0]                         port_we_o,
    output logic [1:0][DataWidth-1:0]          port_wdata_o,
    output logic [1:0][DataWidth/8-1:0]        port_be_o,
    input  logic [1:0]                         port_rvalid_i,
    input  logic [1:0][DataWidth-1:0]          port_rdata_i
);
    localparam int unsigned IdW     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW    = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutst + 1);
    localparam int unsigned PortBit = $clog2(PortSize);

    typedef logic [IdW-1:0] id_t;

    logic [NumReq-1:0]                tgt, miss, err_pend, dec_gnt;
    logic [NumReq-1:0][AddrWidth-1:0] rel_addr;
    logic [1:0][IdW-1:0]              ptr_q, win, head;
    logic [1:0]                       found, full, empty, hs, pop;
    logic [1:0][NumReq-1:0]           elig;
    id_t                              fifo_q [2][MaxOutst];
    logic [1:0][PtrW-1:0]             wr_q, rd_q;
    logic [1:0][CntW-1:0]             fcnt_q;
    logic [NumReq-1:0][1:0][CntW-1:0] cnt_q;
    id_t                              idx;

`ifdef CARFIELD_L2ARB_DECERR_EN
    logic [NumReq-1:0][AddrWidth-1:0] offs;
    logic [NumReq-1:0]                err_pend_q;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            offs[i]     = addr_i[i] - L2Base;
            miss[i]     = (addr_i[i] < L2Base) || (offs[i] >= (PortSize << 1));
            tgt[i]      = offs[i][PortBit];
            rel_addr[i] = offs[i] & (PortSize - 1'b1);
        end
    end

    // A miss is answered locally, only once the requester has nothing in flight on either port.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            dec_gnt[i] = ~rst_i & req_i[i] & miss[i] & ~err_pend_q[i] &
                         (cnt_q[i][0] == '0) & (cnt_q[i][1] == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pend_q <= '0;
        end else begin
            err_pend_q <= dec_gnt;
        end
    end

    assign err_pend = err_pend_q;
`else
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            miss[i]     = 1'b0;
            tgt[i]      = addr_i[i][PortBit];
            rel_addr[i] = addr_i[i] & (PortSize - 1'b1);
        end
    end

    assign dec_gnt  = '0;
    assign err_pend = '0;
`endif

    // Blocking requesters with traffic on the other port keeps responses in order per requester.
    always_comb begin
        elig  = '0;
        found = '0;
        win   = '0;
        idx   = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NumReq; i++) begin
                elig[p][i] = req_i[i] & ~miss[i] & (tgt[i] == p[0]) &
                             (cnt_q[i][p ^ 1] == '0) & ~err_pend[i];
            end
            for (int k = 0; k < NumReq; k++) begin
                idx = IdW'((32'(ptr_q[p]) + 32'(k)) % NumReq);
                if (!found[p] && elig[p][idx]) begin
                    found[p] = 1'b1;
                    win[p]   = idx;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            full[p]         = (fcnt_q[p] == CntW'(MaxOutst));
            empty[p]        = (fcnt_q[p] == '0);
            port_req_o[p]   = ~rst_i & found[p] & ~full[p];
            hs[p]           = port_req_o[p] & port_gnt_i[p];
            pop[p]          = ~rst_i & port_rvalid_i[p] & ~empty[p];
            head[p]         = fifo_q[p][rd_q[p]];
            port_addr_o[p]  = port_req_o[p] ? rel_addr[win[p]] : '0;
            port_we_o[p]    = port_req_o[p] & we_i[win[p]];
            port_wdata_o[p] = port_req_o[p] ? wdata_i[win[p]] : '0;
            port_be_o[p]    = port_req_o[p] ? be_i[win[p]] : '0;
        end
    end

    always_comb begin
        gnt_o    = dec_gnt;
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
                gnt_o[win[p]] = 1'b1;
            end
            if (pop[p]) begin
                rvalid_o[head[p]] = 1'b1;
                rdata_o[head[p]]  = port_rdata_i[p];
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (err_pend[i] && !rst_i) begin
                rvalid_o[i] = 1'b1;
                err_o[i]    = 1'b1;
                rdata_o[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    ptr_q[p]            <= (32'(win[p]) == NumReq - 1) ? '0 : win[p] + 1'b1;
                    fifo_q[p][wr_q[p]]  <= win[p];
                    wr_q[p]             <= (32'(wr_q[p]) == MaxOutst - 1) ? '0 : wr_q[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_q[p] <= (32'(rd_q[p]) == MaxOutst - 1) ? '0 : rd_q[p] + 1'b1;
                end
                fcnt_q[p] <= fcnt_q[p] + CntW'(hs[p]) - CntW'(pop[p]);
            end
            for (int i = 0; i < NumReq; i++) begin
                for (int p = 0; p < 2; p++) begin
                    cnt_q[i][p] <= cnt_q[i][p] + CntW'(hs[p] && (win[p] == IdW'(i)))
                                               - CntW'(pop[p] && (head[p] == IdW'(i)));
                end
            end
        end
    end

endmodule

// File: tb/tb_carfield_l2_port_arbiter.sv
// Scoreboard bench for carfield_l2_port_arbiter: requester queues, a latency-based L2 model
// and per-requester expected-response queues.
module tb_carfield_l2_port_arbiter;
    localparam int          NR  = 4;
    localparam logic [47:0] L2B = 48'h78000000;
    localparam logic [47:0] PS  = 48'h00200000;

    typedef struct { logic [47:0] addr; logic we; } rq_t;
    typedef struct { logic err; logic [63:0] data; } exp_t;
    typedef struct { int due; logic [63:0] data; } l2_t;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [NR-1:0]          req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [NR-1:0][47:0]    addr_i;
    logic [NR-1:0][63:0]    wdata_i, rdata_o;
    logic [NR-1:0][7:0]     be_i;
    logic [1:0]             port_req_o, port_gnt_i, port_we_o, port_rvalid_i;
    logic [1:0][47:0]       port_addr_o;
    logic [1:0][63:0]       port_wdata_o, port_rdata_i;
    logic [1:0][7:0]        port_be_o;

    carfield_l2_port_arbiter #(
        .NumReq(4), .AddrWidth(48), .DataWidth(64),
        .L2Base(48'h78000000), .PortSize(48'h00200000), .MaxOutst(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .port_req_o(port_req_o), .port_gnt_i(port_gnt_i),
        .port_addr_o(port_addr_o), .port_we_o(port_we_o), .port_wdata_o(port_wdata_o),
        .port_be_o(port_be_o), .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         l2_lat = 3;
    logic [1:0] l2_gnt = 2'b11;
    logic [1:0] l2_hold = 2'b00;
    logic [NR-1:0] gnt_seen = '0;
    logic       p1_req_seen;
    rq_t        rq [NR][$];
    exp_t       exp_q [NR][$];
    l2_t        l2_q [2][$];
    int         gnt_log [$];

    logic [NR-1:0] obs_gnt, obs_rvalid, obs_err;
    logic [1:0]    obs_preq, obs_pwe;
    logic [47:0]   obs_paddr0, obs_paddr1;
    logic [63:0]   obs_rdata0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic p, input logic [47:0] rel, input logic we);
        return 64'hDEAD ^ ({16'h0, rel ^ 48'h10} << 16) ^ ({63'h0, p} << 60) ^ ({63'h0, we} << 61);
    endfunction

    function automatic exp_t model(input logic [47:0] a, input logic we);
        exp_t        e;
        logic [47:0] off;
        e.err  = 1'b0;
        e.data = '0;
`ifdef CARFIELD_L2ARB_DECERR_EN
        if (a < L2B || a >= L2B + 48'(2) * PS) begin
            e.err = 1'b1;
            return e;
        end
        off = a - L2B;
`else
        off = a;
`endif
        e.data = mkdata(off[21], off & (PS - 48'h1), we);
        return e;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += rq[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic tick();
        rq_t  r;
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            if (gnt_seen[i]) req_i[i] = 1'b0;
            if (!req_i[i] && rq[i].size() > 0) begin
                r = rq[i].pop_front();
                req_i[i]   = 1'b1;
                addr_i[i]  = r.addr;
                we_i[i]    = r.we;
                wdata_i[i] = {16'h5A5A, r.addr};
                be_i[i]    = 8'hFF;
                exp_q[i].push_back(model(r.addr, r.we));
            end
        end
        for (int p = 0; p < 2; p++) begin
            port_gnt_i[p]    = l2_gnt[p];
            port_rvalid_i[p] = 1'b0;
            port_rdata_i[p]  = '0;
            if (!l2_hold[p] && l2_q[p].size() > 0 && l2_q[p][0].due <= cyc) begin
                port_rvalid_i[p] = 1'b1;
                port_rdata_i[p]  = l2_q[p][0].data;
            end
        end
        @(negedge clk);
        gnt_seen   = gnt_o;
        obs_gnt    = gnt_o;
        obs_rvalid = rvalid_o;
        obs_err    = err_o;
        obs_preq   = port_req_o;
        obs_pwe    = port_we_o;
        obs_paddr0 = port_addr_o[0];
        obs_paddr1 = port_addr_o[1];
        obs_rdata0 = rdata_o[0];
        for (int p = 0; p < 2; p++) begin
            if (port_rvalid_i[p]) l2_q[p].delete(0);
            if (port_req_o[p] && port_gnt_i[p])
                l2_q[p].push_back('{due: cyc + l2_lat,
                                    data: mkdata(p[0], port_addr_o[p], port_we_o[p])});
        end
        if (port_req_o[1]) p1_req_seen = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (gnt_o[i]) gnt_log.push_back(i);
            if (rvalid_o[i]) begin
                if (exp_q[i].size() == 0) begin
                    check_eq($sformatf("spurious_rvalid%0d", i), 64'(rvalid_o[i]), 64'h0);
                end else begin
                    e = exp_q[i].pop_front();
                    check_eq($sformatf("rdata%0d", i), rdata_o[i], e.data);
                    check_eq($sformatf("err%0d", i), 64'(err_o[i]), 64'(e.err));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        l2_hold = 2'b00;
        while (n < 60 && pending() != 0) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(pending()), 64'h0);
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        req_i    = '0;
        gnt_seen = '0;
        for (int p = 0; p < 2; p++) l2_q[p].delete();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            exp_q[i].delete();
        end
        gnt_log.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        req_i         = '1;
        we_i          = '0;
        wdata_i       = '0;
        be_i          = '1;
        for (int i = 0; i < NR; i++) addr_i[i] = L2B;
        port_gnt_i    = 2'b11;
        port_rvalid_i = 2'b11;
        port_rdata_i  = '1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_port_req", 64'(port_req_o), 64'h0);
        check_eq("rst_gnt", 64'(gnt_o), 64'h0);
        check_eq("rst_rvalid", 64'(rvalid_o), 64'h0);
        check_eq("rst_port_addr", 64'(port_addr_o[0]), 64'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = '0;
        @(negedge clk);
        check_eq("post_rst_drop", 64'(rvalid_o), 64'h0);
        @(posedge clk);
        #1;

        // single read
        rq[0].push_back('{addr: 48'h78000010, we: 1'b0});
        tick();
        check_eq("single_gnt", 64'(obs_gnt), 64'h1);
        check_eq("single_port_req", 64'(obs_preq), 64'h1);
        check_eq("single_port_addr", 64'(obs_paddr0), 64'h10);
        tick();
        tick();
        check_eq("single_early", 64'(obs_rvalid), 64'h0);
        tick();
        check_eq("single_rvalid", 64'(obs_rvalid), 64'h1);
        check_eq("single_rdata", obs_rdata0, 64'hDEAD);
        drain();

        // fairness
        do_reset();
        p1_req_seen = 1'b0;
        for (int i = 0; i < NR; i++)
            for (int n = 0; n < 2; n++)
                rq[i].push_back('{addr: L2B + 48'(i * 'h100 + n * 8), we: 1'(n)});
        repeat (10) tick();
        check_eq("fair_count", 64'(gnt_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            check_eq($sformatf("fair_order%0d", k), 64'(gnt_log[k]), 64'(k % 4));
        check_eq("fair_port1_idle", 64'(p1_req_seen), 64'h0);
        drain();

        // dual port
        do_reset();
        rq[0].push_back('{addr: 48'h78000000, we: 1'b0});
        rq[1].push_back('{addr: 48'h78200000, we: 1'b1});
        tick();
        check_eq("dual_gnt", 64'(obs_gnt), 64'h3);
        check_eq("dual_port_req", 64'(obs_preq), 64'h3);
        check_eq("dual_port_addr1", 64'(obs_paddr1), 64'h0);
        check_eq("dual_port_we", 64'(obs_pwe), 64'h2);
        drain();

        // FIFO full
        do_reset();
        l2_hold = 2'b01;
        for (int n = 0; n < 3; n++) begin
            rq[0].push_back('{addr: L2B + 48'('h100 + n * 8), we: 1'b0});
            rq[1].push_back('{addr: L2B + 48'('h200 + n * 8), we: 1'b0});
        end
        repeat (8) tick();
        check_eq("full_grants", 64'(gnt_log.size()), 64'd4);
        check_eq("full_req_low", 64'(obs_preq[0]), 64'h0);
        l2_hold = 2'b00;
        tick();
        check_eq("full_pop", 64'(obs_rvalid[0]), 64'h1);
        check_eq("full_no_bypass", 64'(obs_preq[0]), 64'h0);
        l2_hold = 2'b01;
        tick();
        check_eq("full_reenable", 64'(obs_preq[0]), 64'h1);
        check_eq("full_grants_after", 64'(gnt_log.size()), 64'd5);
        drain();

        // cross-port hazard
        do_reset();
        l2_hold = 2'b01;
        rq[2].push_back('{addr: 48'h78000020, we: 1'b0});
        tick();
        check_eq("xport_first_gnt", 64'(obs_gnt), 64'h4);
        rq[2].push_back('{addr: 48'h78200040, we: 1'b0});
        repeat (4) begin
            tick();
            check_eq("xport_blocked", 64'(obs_gnt[2]), 64'h0);
            check_eq("xport_port1_idle", 64'(obs_preq[1]), 64'h0);
        end
        l2_hold = 2'b00;
        tick();
        check_eq("xport_resp", 64'(obs_rvalid[2]), 64'h1);
        check_eq("xport_still_blocked", 64'(obs_gnt[2]), 64'h0);
        tick();
        check_eq("xport_gnt", 64'(obs_gnt[2]), 64'h1);
        check_eq("xport_port1_req", 64'(obs_preq[1]), 64'h1);
        drain();

        // out-of-window address
        do_reset();
        rq[3].push_back('{addr: 48'h60000000, we: 1'b0});
        tick();
        check_eq("miss_gnt", 64'(obs_gnt), 64'h8);
`ifdef CARFIELD_L2ARB_DECERR_EN
        check_eq("decerr_no_port", 64'(obs_preq), 64'h0);
        tick();
        check_eq("decerr_rvalid", 64'(obs_rvalid[3]), 64'h1);
        check_eq("decerr_err", 64'(obs_err[3]), 64'h1);
`else
        check_eq("nodec_port_req", 64'(obs_preq), 64'h1);
        check_eq("nodec_port_addr", 64'(obs_paddr0), 64'h0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
